alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Multi-cycle driver on the initiator side of the datapath ALU. It accepts one 5-bit CPU opcode with two operands over a valid/ready handshake and decodes it into the ALU's one-hot operation strobes. It holds the operands and strobe stable for a programmable settle time, then captures the ALU's 64-bit result into the Z registers, and into HI/LO for MUL and DIV. It sits between the control unit and the combinational ALU.

## Interface
- DATA_W, 32, operand/result half-width
- SETTLE_CYCLES, 1, DRIVE cycles for single-cycle ops (≥1)
- MULDIV_SETTLE, 4, DRIVE cycles for MUL/DIV (≥1)

- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous, active-high reset
- op_valid  in  1  request valid
- op_ready  out  1  sequencer can accept (high in IDLE)
- opcode  in  5  CPU opcode
- op_a  in  DATA_W  operand A
- op_b  in  DATA_W  operand B
- alu_a  out  DATA_W  latched A to ALU
- alu_b  out  DATA_W  latched B to ALU
- alu_ctl  out  14  one-hot strobes: [0]ADD [1]SUB [2]MUL [3]DIV [4]AND [5]OR [6]SHR [7]SHRA [8]SHL [9]ROR [10]ROL [11]NEG [12]NOT [13]IncPC
- alu_chigh  in  DATA_W  ALU result high half
- alu_clow  in  DATA_W  ALU result low half
- z_hi, z_lo  out  DATA_W each  captured result
- hi_reg, lo_reg  out  DATA_W each  MUL/DIV result
- done  out  1  one-cycle pulse after capture
- illegal  out  1  one-cycle pulse on rejected opcode

## Operation
- Opcode map:
  - ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001
  - AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010, IncPC 11111
  - All other codes are illegal.
- States: IDLE, DRIVE, CAPTURE.
- IDLE:
  - op_ready=1 and alu_ctl=0.
  - alu_a/alu_b hold their last latched values.
  - A transfer occurs on a rising edge where op_valid and op_ready are both high.
- Transfer with a legal opcode:
  - Latch opcode, op_a and op_b.
  - Load the counter with SETTLE_CYCLES-1, or MULDIV_SETTLE-1 for MUL/DIV.
  - Go to DRIVE.
- Transfer with an illegal opcode:
  - Stay in IDLE.
  - illegal=1 for the next cycle.
  - alu_ctl stays 0; no result register changes.
- DRIVE:
  - alu_ctl is one-hot per the latched opcode; op_ready=0.
  - Counter decrements each cycle; at 0, go to CAPTURE.
- CAPTURE:
  - alu_ctl is still asserted.
  - On the closing edge, z_hi←alu_chigh and z_lo←alu_clow.
  - If MUL/DIV, also hi_reg←alu_chigh and lo_reg←alu_clow.
  - done=1 for the next cycle; go to IDLE.
- The counter is wide enough for max(SETTLE_CYCLES, MULDIV_SETTLE); it never wraps.
- op_a/op_b/opcode changes while the sequencer is busy are ignored. Operands are sampled only at transfer.

## Timing
- Reset values (clear high, applied asynchronously):
  - State IDLE; alu_ctl=0; done=0; illegal=0.
  - alu_a, alu_b, z_hi, z_lo, hi_reg, hi_reg, lo_reg = 0.
  - op_ready=1, but no transfer is taken while clear is high.
- Clear mid-operation: alu_ctl drops to 0 immediately (asynchronously). No capture occurs and done does not pulse.
- Latency, with transfer at edge T:
  - DRIVE occupies N cycles, where N = SETTLE_CYCLES or MULDIV_SETTLE.
  - CAPTURE is 1 cycle.
  - Capture happens at edge T+N+1; done is high in the cycle after it.
  - alu_ctl is asserted for exactly N+1 cycles.
- op_ready returns high in the same cycle as done. A new transfer at that edge is legal (back-to-back). Throughput is one op per N+2 cycles.
- illegal and done are registered, glitch-free, and never high together.

## Test plan
- ADD: op_a=5, op_b=7, SETTLE_CYCLES=1 → alu_ctl=14'h0001 for 2 cycles; at done z_lo=12, z_hi=0; hi_reg/lo_reg unchanged.
- MUL (bench ALU model): op_a=32'hFFFF_FFFF (−1), op_b=3, MULDIV_SETTLE=4 → alu_ctl bit2 held exactly 5 cycles; done 6 cycles after transfer; hi_reg=32'hFFFF_FFFF, lo_reg=32'hFFFF_FFFD.
- Illegal opcode 00000 → illegal pulses once; alu_ctl stays 0; z/hi/lo unchanged; op_ready never drops.
- Back-to-back: op_valid held high with AND(F0F0,FF00), then OR(F0F0,0F0F) → second transfer on the done edge; results z_lo=F000 then FFFF; no idle cycle between.
- Clear mid-DIV (2nd DRIVE cycle) → alu_ctl=0 within the same cycle; all registers 0; no done. After release, NOT(B=0) yields z_lo=FFFF_FFFF.
- IncPC opcode 11111 with op_b=41 → alu_ctl=14'h2000; z_lo=42.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request handshake, ALU drive/result and capture bus of the sequencer
interface alu_op_sequencer_if #(parameter int DATA_W = 32);
  logic              op_valid;
  logic              op_ready;
  logic [4:0]        opcode;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [13:0]       alu_ctl;
  logic [DATA_W-1:0] alu_chigh;
  logic [DATA_W-1:0] alu_clow;
  logic [DATA_W-1:0] z_hi;
  logic [DATA_W-1:0] z_lo;
  logic [DATA_W-1:0] hi_reg;
  logic [DATA_W-1:0] lo_reg;
  logic              done;
  logic              illegal;
  modport master (
    output op_valid, opcode, op_a, op_b, alu_chigh, alu_clow,
    input  op_ready, alu_a, alu_b, alu_ctl, z_hi, z_lo, hi_reg, lo_reg, done, illegal
  );
  modport slave (
    input  op_valid, opcode, op_a, op_b, alu_chigh, alu_clow,
    output op_ready, alu_a, alu_b, alu_ctl, z_hi, z_lo, hi_reg, lo_reg, done, illegal
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: decodes CPU opcodes into ALU strobes, holds them for a settle time, captures the result
module alu_op_sequencer #(
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 1,
  parameter int MULDIV_SETTLE = 4
) (
  input logic               clock,
  input logic               clear,
  alu_op_sequencer_if.slave bus
);
  localparam int MAX_N = SETTLE_CYCLES > MULDIV_SETTLE ? SETTLE_CYCLES : MULDIV_SETTLE;
  localparam int CNT_W = MAX_N > 1 ? $clog2(MAX_N) : 1;
  localparam logic [CNT_W-1:0] LOAD_S = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_M = CNT_W'(MULDIV_SETTLE - 1);
  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE} state_t;
  state_t            state, state_n;
  logic [13:0]       dec;
  logic [13:0]       ctl_q;
  logic [CNT_W-1:0]  cnt;
  logic              muldiv_q;
  logic              legal;
  logic              dec_muldiv;
  logic              xfer;
  logic [DATA_W-1:0] a_q, b_q, zh_q, zl_q, hi_q, lo_q;
  logic              done_q, illegal_q;
  // opcode to one-hot strobe decode; unknown codes decode to zero and are rejected
  always_comb begin
    dec = '0;
    case (bus.opcode)
      5'b00011: dec[0]  = 1'b1;
      5'b00100: dec[1]  = 1'b1;
      5'b01111: dec[2]  = 1'b1;
      5'b10000: dec[3]  = 1'b1;
      5'b01010: dec[4]  = 1'b1;
      5'b01011: dec[5]  = 1'b1;
      5'b00101: dec[6]  = 1'b1;
      5'b00110: dec[7]  = 1'b1;
      5'b00111: dec[8]  = 1'b1;
      5'b01000: dec[9]  = 1'b1;
      5'b01001: dec[10] = 1'b1;
      5'b10001: dec[11] = 1'b1;
      5'b10010: dec[12] = 1'b1;
      5'b11111: dec[13] = 1'b1;
      default:  dec     = '0;
    endcase
  end
  assign legal      = |dec;
  assign dec_muldiv = dec[2] | dec[3];
  assign xfer       = bus.op_valid && bus.op_ready;
  assign bus.op_ready = state == IDLE;
  assign bus.alu_ctl  = state == IDLE ? '0 : ctl_q;
  assign bus.alu_a    = a_q;
  assign bus.alu_b    = b_q;
  assign bus.z_hi     = zh_q;
  assign bus.z_lo     = zl_q;
  assign bus.hi_reg   = hi_q;
  assign bus.lo_reg   = lo_q;
  assign bus.done     = done_q;
  assign bus.illegal  = illegal_q;
  // state register; clear forces IDLE so the strobes drop without waiting for a clock
  always_ff @(posedge clock or posedge clear)
    if (clear) state <= IDLE;
    else state <= state_n;
  // next state: legal transfer starts DRIVE, counter expiry moves to CAPTURE, CAPTURE always returns
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (xfer && legal ? DRIVE : IDLE) :
              state == DRIVE ? (cnt == '0 ? CAPTURE : DRIVE) : IDLE;
  end
  // operand/strobe latching, settle counter, result capture and the two status pulses
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      a_q       <= '0;
      b_q       <= '0;
      ctl_q     <= '0;
      muldiv_q  <= 1'b0;
      cnt       <= '0;
      zh_q      <= '0;
      zl_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (xfer && legal) begin
        a_q      <= bus.op_a;
        b_q      <= bus.op_b;
        ctl_q    <= dec;
        muldiv_q <= dec_muldiv;
        cnt      <= dec_muldiv ? LOAD_M : LOAD_S;
      end else if (state == DRIVE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == CAPTURE) begin
        zh_q <= bus.alu_chigh;
        zl_q <= bus.alu_clow;
        if (muldiv_q) begin
          hi_q <= bus.alu_chigh;
          lo_q <= bus.alu_clow;
        end
      end
      done_q    <= state == CAPTURE;
      illegal_q <= xfer && !legal;
    end
  end
endmodule
